// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for the sequential magnitude comparator:
//   - compare codes in {G,L} form (G = A>B, L = A<B, neither = equal)
//   - FSM state encoding for cmp_seq_nibble
// -----------------------------------------------------------------------------
package cmp_pkg;

   localparam logic [1:0] CMP_EQ = 2'b00;
   localparam logic [1:0] CMP_LT = 2'b01;
   localparam logic [1:0] CMP_GT = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : cmp_pkg

// File: rtl/nibble_cmp.sv
// -----------------------------------------------------------------------------
// nibble_cmp
// Purely combinational 4-bit unsigned magnitude compare.
// Ports:
//   x    : first nibble (A side)
//   y    : second nibble (B side)
//   code : {G,L} compare code, CMP_GT / CMP_LT / CMP_EQ
// -----------------------------------------------------------------------------
module nibble_cmp
   import cmp_pkg::*;
(
   input  logic [3:0] x,
   input  logic [3:0] y,
   output logic [1:0] code
);

   always_comb begin
      code = CMP_EQ;
      if (x > y) begin
         code = CMP_GT;
      end else if (x < y) begin
         code = CMP_LT;
      end
   end

endmodule : nibble_cmp

// File: rtl/cmp_seq_nibble.sv
// -----------------------------------------------------------------------------
// cmp_seq_nibble
// Sequential wide magnitude comparator. Accepts an operand pair, then scans it
// one nibble per clock from the most significant nibble down, stopping on the
// first unequal nibble. Signed compares flip bit 3 of the top nibble pair so the
// unsigned nibble compare orders two's complement values correctly.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. in_ready is high only in IDLE; out_valid is high only in DONE, and
// o/out_valid stay stable until the edge where out_ready is 1.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : operand pair offered        in_ready  : pair can be accepted
//   a, b       : WIDTH-bit operands          is_signed : two's complement compare
//   out_valid  : result available            out_ready : consumer takes result
//   o          : {G,L} compare code (10 A>B, 01 A<B, 00 A==B)
// -----------------------------------------------------------------------------
module cmp_seq_nibble
   import cmp_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int NIB   = WIDTH / 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       o
);

   localparam int            IW      = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IW-1:0] TOP_IDX = IW'(NIB - 1);

   state_e           state;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             sgn_q;

   logic [3:0]       nib_a;
   logic [3:0]       nib_b;
   logic [3:0]       nib_a_adj;
   logic [3:0]       nib_b_adj;
   logic             flip;
   logic [1:0]       nib_code;

   // Nibble select by index; written as a compare loop so that non power-of-two
   // nibble counts never form an out-of-range part select.
   always_comb begin
      nib_a = 4'h0;
      nib_b = 4'h0;
      for (int i = 0; i < NIB; i++) begin
         if (idx == IW'(i)) begin
            nib_a = a_q[i*4 +: 4];
            nib_b = b_q[i*4 +: 4];
         end
      end
   end

   // Offset-binary trick: inverting the sign bit of the top nibble turns a
   // signed ordering into an unsigned one. Lower nibbles are plain magnitude.
   assign flip      = sgn_q && (idx == TOP_IDX);
   assign nib_a_adj = nib_a ^ {flip, 3'b000};
   assign nib_b_adj = nib_b ^ {flip, 3'b000};

   nibble_cmp u_nibble_cmp (
      .x    (nib_a_adj),
      .y    (nib_b_adj),
      .code (nib_code)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         o         <= CMP_EQ;
         idx       <= TOP_IDX;
         a_q       <= '0;
         b_q       <= '0;
         sgn_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= a;
                  b_q      <= b;
                  sgn_q    <= is_signed;
                  idx      <= TOP_IDX;
                  in_ready <= 1'b0;
                  state    <= SCAN;
               end
            end
            SCAN: begin
               if (nib_code != CMP_EQ) begin
                  o         <= nib_code;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (idx == '0) begin
                  o         <= CMP_EQ;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule : cmp_seq_nibble

// File: tb/tb_cmp_seq_nibble.sv
module tb_cmp_seq_nibble;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // WIDTH=16 instance
   logic        in_valid16 = 1'b0;
   logic        in_ready16;
   logic [15:0] a16 = '0;
   logic [15:0] b16 = '0;
   logic        sgn16 = 1'b0;
   logic        out_valid16;
   logic        out_ready16 = 1'b0;
   logic [1:0]  o16;

   // WIDTH=4 instance
   logic        in_valid4 = 1'b0;
   logic        in_ready4;
   logic [3:0]  a4 = '0;
   logic [3:0]  b4 = '0;
   logic        sgn4 = 1'b0;
   logic        out_valid4;
   logic        out_ready4 = 1'b0;
   logic [1:0]  o4;

   int n_cmp = 0;
   int n_err = 0;

   cmp_seq_nibble #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .is_signed(sgn16),
      .out_valid(out_valid16), .out_ready(out_ready16), .o(o16)
   );

   cmp_seq_nibble #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .is_signed(sgn4),
      .out_valid(out_valid4), .out_ready(out_ready4), .o(o4)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs are driven and outputs sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer a pair to the 16-bit DUT, wait for the result, check code and latency.
   // hold = cycles of backpressure (with noise on inputs) before out_ready.
   task automatic run16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic s, input logic [1:0] exp_o, input int exp_lat,
                        input int hold);
      int lat;
      check({tag, ":in_ready_idle"}, 32'(in_ready16), 32'd1);
      a16 = av; b16 = bv; sgn16 = s; in_valid16 = 1'b1;
      tick();
      in_valid16 = 1'b0;
      a16 = 16'(~av); b16 = 16'(~bv); sgn16 = ~s;   // must be ignored
      lat = 0;
      do begin
         check({tag, ":in_ready_busy"}, 32'(in_ready16), 32'd0);
         tick();
         lat++;
      end while (!out_valid16 && lat < 8);
      check({tag, ":out_valid"}, 32'(out_valid16), 32'd1);
      check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
      check({tag, ":o"}, 32'(o16), 32'(exp_o));
      for (int i = 0; i < hold; i++) begin
         in_valid16 = 1'b1;
         a16 = 16'($urandom_range(0, 65535));
         b16 = 16'($urandom_range(0, 65535));
         tick();
         check({tag, ":hold_valid"}, 32'(out_valid16), 32'd1);
         check({tag, ":hold_o"}, 32'(o16), 32'(exp_o));
         check({tag, ":hold_ready"}, 32'(in_ready16), 32'd0);
      end
      in_valid16 = 1'b0;
      out_ready16 = 1'b1;
      tick();
      out_ready16 = 1'b0;
      check({tag, ":released"}, 32'(out_valid16), 32'd0);
      check({tag, ":back_idle"}, 32'(in_ready16), 32'd1);
   endtask

   task automatic run4(input logic [3:0] av, input logic [3:0] bv, input logic s,
                       input logic [1:0] exp_o);
      int lat;
      a4 = av; b4 = bv; sgn4 = s; in_valid4 = 1'b1;
      tick();
      in_valid4 = 1'b0;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!out_valid4 && lat < 4);
      check("w4:latency", 32'(lat), 32'd1);
      check("w4:o", 32'({a4, b4, sgn4, o4}), 32'({av, bv, s, exp_o}));
      out_ready4 = 1'b1;
      tick();
      out_ready4 = 1'b0;
      check("w4:idle", 32'({in_ready4, out_valid4}), 32'b10);
   endtask

   initial begin
      logic [1:0] e;
      int seen;

      // reset state
      rst = 1'b1;
      tick(); tick();
      check("rst:in_ready16", 32'(in_ready16), 32'd1);
      check("rst:out_valid16", 32'(out_valid16), 32'd0);
      check("rst:o16", 32'(o16), 32'd0);
      check("rst:in_ready4", 32'(in_ready4), 32'd1);
      check("rst:out_valid4", 32'(out_valid4), 32'd0);
      rst = 1'b0;
      tick();

      // directed compares, hand-computed expected codes and latencies
      run16("eq_u",      16'h1234, 16'h1234, 1'b0, 2'b00, 4, 0);
      run16("gt_u_top",  16'h9000, 16'h1000, 1'b0, 2'b10, 1, 0);
      run16("lt_s_top",  16'h9000, 16'h1000, 1'b1, 2'b01, 1, 0);
      run16("lt_u_nib0", 16'h12A4, 16'h12A5, 1'b0, 2'b01, 4, 0);
      run16("lt_s_min",  16'h8000, 16'h7FFF, 1'b1, 2'b01, 1, 0);
      run16("gt_s_neg",  16'hFFFF, 16'hFFFE, 1'b1, 2'b10, 4, 0);
      run16("eq_s",      16'h8001, 16'h8001, 1'b1, 2'b00, 4, 0);
      run16("gt_s_nib2", 16'hF700, 16'hF600, 1'b1, 2'b10, 2, 0);

      // backpressure with in_valid high and operands toggling, then a fresh compare
      run16("bp",        16'h0300, 16'h0200, 1'b0, 2'b10, 2, 3);
      run16("after_bp",  16'h0040, 16'h0050, 1'b0, 2'b01, 3, 0);

      // reset on the 2nd SCAN edge of a compare that would finish after 4 edges
      a16 = 16'h1111; b16 = 16'h1112; sgn16 = 1'b0; in_valid16 = 1'b1;
      tick();                 // acceptance edge
      in_valid16 = 1'b0;
      tick();                 // 1st SCAN edge
      rst = 1'b1;
      tick();                 // 2nd SCAN edge, reset taken
      rst = 1'b0;
      check("midrst:in_ready", 32'(in_ready16), 32'd1);
      check("midrst:out_valid", 32'(out_valid16), 32'd0);
      check("midrst:o", 32'(o16), 32'd0);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (out_valid16) seen++;
      end
      check("midrst:no_result", 32'(seen), 32'd0);
      run16("post_rst",  16'h0005, 16'h0003, 1'b0, 2'b10, 4, 0);

      // WIDTH=4: every pair, unsigned then signed
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
               if (s == 0) begin
                  e = (i > j) ? 2'b10 : (i < j) ? 2'b01 : 2'b00;
               end else begin
                  e = ($signed(4'(i)) > $signed(4'(j))) ? 2'b10 :
                      ($signed(4'(i)) < $signed(4'(j))) ? 2'b01 : 2'b00;
               end
               run4(4'(i), 4'(j), s[0], e);
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global time limit so the bench always ends.
   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "time limit");
   end

endmodule : tb_cmp_seq_nibble
